// File: rtl/lbdr_adaptive_route_unit_pkg.sv
// ---------------------------------------------------------------------------
// lbdr_pkg
// Shared types and constants for the adaptive LBDR route unit:
//   - flit type codes carried on flit_id
//   - output port index enum (bit positions of the one-hot out_port)
//   - route FSM state enum
//   - first_set4(): isolates the lowest set bit of a 4-bit candidate vector,
//     which is how the fixed N>E>W>S priority is realised.
// ---------------------------------------------------------------------------
package lbdr_pkg;

  localparam int FLIT_W = 3;

  localparam logic [FLIT_W-1:0] FLIT_HEADER = 3'b001;
  localparam logic [FLIT_W-1:0] FLIT_BODY   = 3'b010;
  localparam logic [FLIT_W-1:0] FLIT_TAIL   = 3'b100;
  localparam logic [FLIT_W-1:0] FLIT_HT     = 3'b101;

  typedef enum logic [2:0] {
    P_N = 3'd0,
    P_E = 3'd1,
    P_W = 3'd2,
    P_S = 3'd3,
    P_L = 3'd4
  } port_idx_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOCK = 2'd1,
    DROP = 2'd2
  } state_e;

  // Bit 0 is N, so the lowest set bit is the highest-priority candidate.
  function automatic logic [3:0] first_set4(input logic [3:0] v);
    return v & (~v + 4'd1);
  endfunction

endpackage

// File: rtl/lbdr_adaptive_route_unit_if.sv
// ---------------------------------------------------------------------------
// lbdr_adaptive_route_unit_if
// Flit-side and allocator-side handshake bundle of the route unit.
//   in_valid/in_ready   flit offer / accept from the input FIFO
//   flit_id, dst_addr   flit type and destination {y,x}
//   port_free           downstream free flags {S,W,E,N}
//   out_valid/out_ready one-hot request towards the switch allocator
//   out_port            one-hot {L,S,W,E,N}
//   route_err           one-cycle pulse when a flit was dropped
// master = flit source / allocator side, slave = the route unit.
// ---------------------------------------------------------------------------
interface lbdr_adaptive_route_unit_if
  import lbdr_pkg::*;
#(
  parameter int COORD_W = 2
);

  logic                   in_valid;
  logic                   in_ready;
  logic [FLIT_W-1:0]      flit_id;
  logic [2*COORD_W-1:0]   dst_addr;
  logic [3:0]             port_free;
  logic                   out_valid;
  logic                   out_ready;
  logic [4:0]             out_port;
  logic                   route_err;

  modport master (
    output in_valid, flit_id, dst_addr, port_free, out_ready,
    input  in_ready, out_valid, out_port, route_err
  );

  modport slave (
    input  in_valid, flit_id, dst_addr, port_free, out_ready,
    output in_ready, out_valid, out_port, route_err
  );

endinterface

// File: rtl/lbdr_adaptive_route_unit_route_calc.sv
// ---------------------------------------------------------------------------
// lbdr_route_calc
// Purely combinational LBDR route computation for one header flit.
// Ports:
//   cur_addr_i  this router's {y,x}
//   dst_addr_i  destination {y,x}
//   rxy_i       turn bits {Rsw,Rse,Rws,Rwn,Res,Ren,Rnw,Rne}
//   cx_i        connectivity {Cs,Cw,Ce,Cn}
//   dr_i        deroute port code (0=N 1=E 2=W 3=S)
//   port_free_i downstream free {S,W,E,N}
//   port_o      one-hot {L,S,W,E,N}, zero when the flit must be dropped
//   err_o       1 when no route exists (flit must be dropped)
// ---------------------------------------------------------------------------
module lbdr_route_calc
  import lbdr_pkg::*;
#(
  parameter int COORD_W    = 2,
  parameter bit DEROUTE_EN = 1'b1,
  parameter bit ADAPT_EN   = 1'b1
) (
  input  logic [2*COORD_W-1:0] cur_addr_i,
  input  logic [2*COORD_W-1:0] dst_addr_i,
  input  logic [7:0]           rxy_i,
  input  logic [3:0]           cx_i,
  input  logic [1:0]           dr_i,
  input  logic [3:0]           port_free_i,
  output logic [4:0]           port_o,
  output logic                 err_o
);

  logic [COORD_W-1:0] x_cur_s, y_cur_s, x_dst_s, y_dst_s;
  logic n1_s, s1_s, e1_s, w1_s;
  logic cand_n_s, cand_e_s, cand_w_s, cand_s_s;
  logic [3:0] cand_s;
  logic [3:0] free_cand_s;
  logic local_s;

  assign x_cur_s = cur_addr_i[COORD_W-1:0];
  assign y_cur_s = cur_addr_i[2*COORD_W-1:COORD_W];
  assign x_dst_s = dst_addr_i[COORD_W-1:0];
  assign y_dst_s = dst_addr_i[2*COORD_W-1:COORD_W];

  assign n1_s = (y_dst_s < y_cur_s);
  assign s1_s = (y_cur_s < y_dst_s);
  assign e1_s = (x_cur_s < x_dst_s);
  assign w1_s = (x_dst_s < x_cur_s);

  // A diagonal move may leave on either axis only if the turn bit allows it.
  assign cand_n_s = ((n1_s & ~e1_s & ~w1_s) | (n1_s & e1_s & rxy_i[0]) | (n1_s & w1_s & rxy_i[1])) & cx_i[0];
  assign cand_e_s = ((e1_s & ~n1_s & ~s1_s) | (e1_s & n1_s & rxy_i[2]) | (e1_s & s1_s & rxy_i[3])) & cx_i[1];
  assign cand_w_s = ((w1_s & ~n1_s & ~s1_s) | (w1_s & n1_s & rxy_i[4]) | (w1_s & s1_s & rxy_i[5])) & cx_i[2];
  assign cand_s_s = ((s1_s & ~e1_s & ~w1_s) | (s1_s & e1_s & rxy_i[6]) | (s1_s & w1_s & rxy_i[7])) & cx_i[3];

  assign cand_s      = {cand_s_s, cand_w_s, cand_e_s, cand_n_s};
  assign free_cand_s = cand_s & port_free_i;
  assign local_s     = ~(n1_s | s1_s | e1_s | w1_s);

  // Port selection: local, then adaptive/fixed minimal choice, then deroute.
  always_comb begin
    port_o = 5'b00000;
    err_o  = 1'b0;
    if (local_s) begin
      port_o[P_L] = 1'b1;
    end else if (cand_s != 4'b0000) begin
      if (ADAPT_EN && (free_cand_s != 4'b0000)) begin
        port_o = {1'b0, first_set4(free_cand_s)};
      end else begin
        port_o = {1'b0, first_set4(cand_s)};
      end
    end else if (DEROUTE_EN && cx_i[dr_i]) begin
      port_o = {1'b0, 4'b0001 << dr_i};
    end else begin
      err_o = 1'b1;
    end
  end

endmodule

// File: rtl/lbdr_adaptive_route_unit.sv
// ---------------------------------------------------------------------------
// lbdr_adaptive_route_unit
// Per-input-port route computation with packet-level port locking.
// A header flit is routed by lbdr_route_calc; the chosen port is locked and
// reused for body/tail flits of the same packet. Unroutable packets are
// dropped as a whole (route_err pulses on the header only).
// Ports:
//   clk, rst         clock, synchronous active-high reset (also loads config)
//   rxy_rst_i        turn bits loaded at reset
//   cx_rst_i         connectivity bits loaded at reset
//   dr_rst_i         deroute port code loaded at reset
//   cur_addr_rst_i   router address {y,x} loaded at reset
//   bus              handshake bundle (slave side)
// ---------------------------------------------------------------------------
module lbdr_adaptive_route_unit
  import lbdr_pkg::*;
#(
  parameter int COORD_W    = 2,
  parameter bit DEROUTE_EN = 1'b1,
  parameter bit ADAPT_EN   = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [7:0]                 rxy_rst_i,
  input  logic [3:0]                 cx_rst_i,
  input  logic [1:0]                 dr_rst_i,
  input  logic [2*COORD_W-1:0]       cur_addr_rst_i,
  lbdr_adaptive_route_unit_if.slave  bus
);

  logic [7:0]         rxy_q;
  logic [3:0]         cx_q;
  logic [1:0]         dr_q;
  logic [2*COORD_W-1:0] cur_q;

  state_e     state_q;
  logic [4:0] lock_port_q;
  logic       out_valid_q;
  logic [4:0] out_port_q;
  logic       route_err_q;

  logic [4:0] calc_port_s;
  logic       calc_err_s;
  logic       accept_s;
  logic       is_header_s;

  lbdr_route_calc #(
    .COORD_W    (COORD_W),
    .DEROUTE_EN (DEROUTE_EN),
    .ADAPT_EN   (ADAPT_EN)
  ) u_route_calc (
    .cur_addr_i  (cur_q),
    .dst_addr_i  (bus.dst_addr),
    .rxy_i       (rxy_q),
    .cx_i        (cx_q),
    .dr_i        (dr_q),
    .port_free_i (bus.port_free),
    .port_o      (calc_port_s),
    .err_o       (calc_err_s)
  );

  // The output register frees up in the same cycle the allocator consumes it.
  assign bus.in_ready  = ~rst & (~out_valid_q | bus.out_ready);
  assign accept_s      = bus.in_valid & bus.in_ready;
  assign is_header_s   = (bus.flit_id == FLIT_HEADER);

  assign bus.out_valid = out_valid_q;
  assign bus.out_port  = out_port_q;
  assign bus.route_err = route_err_q;

  // Routing configuration: captured only while reset is held.
  always_ff @(posedge clk) begin
    if (rst) begin
      rxy_q <= rxy_rst_i;
      cx_q  <= cx_rst_i;
      dr_q  <= dr_rst_i;
      cur_q <= cur_addr_rst_i;
    end else begin
      rxy_q <= rxy_q;
      cx_q  <= cx_q;
      dr_q  <= dr_q;
      cur_q <= cur_q;
    end
  end

  // Packet FSM plus the single output pipeline register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lock_port_q <= 5'b00000;
      out_valid_q <= 1'b0;
      out_port_q  <= 5'b00000;
      route_err_q <= 1'b0;
    end else begin
      route_err_q <= 1'b0;
      if (bus.out_ready) begin
        out_valid_q <= 1'b0;
      end
      if (accept_s) begin
        case (bus.flit_id)
          FLIT_HEADER, FLIT_HT: begin
            // A new header inside a locked packet means the old packet lost its tail.
            if (state_q == LOCK) begin
              route_err_q <= 1'b1;
            end
            if (calc_err_s) begin
              route_err_q <= 1'b1;
              state_q     <= is_header_s ? DROP : IDLE;
            end else begin
              out_valid_q <= 1'b1;
              out_port_q  <= calc_port_s;
              lock_port_q <= calc_port_s;
              state_q     <= is_header_s ? LOCK : IDLE;
            end
          end
          FLIT_BODY, FLIT_TAIL: begin
            case (state_q)
              IDLE: begin
                route_err_q <= 1'b1;
              end
              LOCK: begin
                out_valid_q <= 1'b1;
                out_port_q  <= lock_port_q;
                if (bus.flit_id == FLIT_TAIL) begin
                  state_q <= IDLE;
                end
              end
              DROP: begin
                if (bus.flit_id == FLIT_TAIL) begin
                  state_q <= IDLE;
                end
              end
              default: begin
                state_q <= IDLE;
              end
            endcase
          end
          default: begin
            route_err_q <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lbdr_adaptive_route_unit.sv
// ---------------------------------------------------------------------------
// Bench for lbdr_adaptive_route_unit. Three instances share the same stimulus:
//   A: ADAPT_EN=1 DEROUTE_EN=1, B: ADAPT_EN=0 DEROUTE_EN=1, C: ADAPT_EN=1 DEROUTE_EN=0
// ---------------------------------------------------------------------------
module tb_lbdr_adaptive_route_unit;
  import lbdr_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [7:0] cfg_rxy;
  logic [3:0] cfg_cx;
  logic [1:0] cfg_dr;
  logic [3:0] cfg_cur;
  logic       in_valid;
  logic [2:0] flit_id;
  logic [3:0] dst_addr;
  logic [3:0] port_free;
  logic       out_ready;

  int tests_run = 0;
  int tests_failed = 0;

  lbdr_adaptive_route_unit_if #(.COORD_W(2)) ifa ();
  lbdr_adaptive_route_unit_if #(.COORD_W(2)) ifb ();
  lbdr_adaptive_route_unit_if #(.COORD_W(2)) ifc ();

  assign ifa.in_valid = in_valid;  assign ifb.in_valid = in_valid;  assign ifc.in_valid = in_valid;
  assign ifa.flit_id = flit_id;    assign ifb.flit_id = flit_id;    assign ifc.flit_id = flit_id;
  assign ifa.dst_addr = dst_addr;  assign ifb.dst_addr = dst_addr;  assign ifc.dst_addr = dst_addr;
  assign ifa.port_free = port_free; assign ifb.port_free = port_free; assign ifc.port_free = port_free;
  assign ifa.out_ready = out_ready; assign ifb.out_ready = out_ready; assign ifc.out_ready = out_ready;

  logic       ov [3];
  logic [4:0] op [3];
  logic       re [3];
  logic       ir [3];
  assign ov[0] = ifa.out_valid; assign ov[1] = ifb.out_valid; assign ov[2] = ifc.out_valid;
  assign op[0] = ifa.out_port;  assign op[1] = ifb.out_port;  assign op[2] = ifc.out_port;
  assign re[0] = ifa.route_err; assign re[1] = ifb.route_err; assign re[2] = ifc.route_err;
  assign ir[0] = ifa.in_ready;  assign ir[1] = ifb.in_ready;  assign ir[2] = ifc.in_ready;

  lbdr_adaptive_route_unit #(.COORD_W(2), .DEROUTE_EN(1'b1), .ADAPT_EN(1'b1)) dut_a (
    .clk(clk), .rst(rst), .rxy_rst_i(cfg_rxy), .cx_rst_i(cfg_cx), .dr_rst_i(cfg_dr),
    .cur_addr_rst_i(cfg_cur), .bus(ifa));
  lbdr_adaptive_route_unit #(.COORD_W(2), .DEROUTE_EN(1'b1), .ADAPT_EN(1'b0)) dut_b (
    .clk(clk), .rst(rst), .rxy_rst_i(cfg_rxy), .cx_rst_i(cfg_cx), .dr_rst_i(cfg_dr),
    .cur_addr_rst_i(cfg_cur), .bus(ifb));
  lbdr_adaptive_route_unit #(.COORD_W(2), .DEROUTE_EN(1'b0), .ADAPT_EN(1'b1)) dut_c (
    .clk(clk), .rst(rst), .rxy_rst_i(cfg_rxy), .cx_rst_i(cfg_cx), .dr_rst_i(cfg_dr),
    .cur_addr_rst_i(cfg_cur), .bus(ifc));

  // ---------------- reference model ----------------
  bit         m_adapt [3];
  bit         m_der   [3];
  logic [7:0] m_rxy;
  logic [3:0] m_cx;
  logic [1:0] m_dr;
  logic [3:0] m_cur;
  int         pk_mode [3];   // 0: between packets, 1: packet routed, 2: packet discarded
  logic [4:0] pk_port [3];

  // Route of a header flit as a one-hot {L,S,W,E,N}; 0 means the flit is dropped.
  function automatic logic [4:0] ref_route(input bit adapt, input bit der, input logic [3:0] cur,
                                           input logic [3:0] dst, input logic [7:0] rxy,
                                           input logic [3:0] cx, input logic [1:0] dr,
                                           input logic [3:0] free);
    int xc, yc, xd, yd;
    bit gn, gs, ge, gw, found;
    int cand[$];
    int pick;
    logic [4:0] r;
    xc = int'(cur[1:0]); yc = int'(cur[3:2]);
    xd = int'(dst[1:0]); yd = int'(dst[3:2]);
    gn = (yd < yc); gs = (yd > yc); ge = (xd > xc); gw = (xd < xc);
    if (!(gn || gs || ge || gw)) return 5'b10000;
    if (gn && cx[0] && (ge ? rxy[0] : (gw ? rxy[1] : 1'b1))) cand.push_back(0);
    if (ge && cx[1] && (gn ? rxy[2] : (gs ? rxy[3] : 1'b1))) cand.push_back(1);
    if (gw && cx[2] && (gn ? rxy[4] : (gs ? rxy[5] : 1'b1))) cand.push_back(2);
    if (gs && cx[3] && (ge ? rxy[6] : (gw ? rxy[7] : 1'b1))) cand.push_back(3);
    if (cand.size() == 0) begin
      if (der && cx[dr]) begin
        r = 5'd1 << dr;
        return r;
      end
      return 5'd0;
    end
    pick = cand[0];
    found = 1'b0;
    if (adapt) begin
      foreach (cand[i]) begin
        if (!found && free[cand[i]]) begin
          pick = cand[i];
          found = 1'b1;
        end
      end
    end
    r = 5'd1 << pick;
    return r;
  endfunction

  task automatic model_flit(input int k, input logic [2:0] f, input logic [3:0] d,
                            output logic ev, output logic [4:0] ep, output logic ee);
    logic [4:0] r;
    ev = 1'b0; ep = 5'd0; ee = 1'b0;
    if (f == FLIT_HEADER || f == FLIT_HT) begin
      if (pk_mode[k] == 1) ee = 1'b1;
      r = ref_route(m_adapt[k], m_der[k], m_cur, d, m_rxy, m_cx, m_dr, port_free);
      if (r == 5'd0) begin
        ee = 1'b1;
        pk_mode[k] = (f == FLIT_HEADER) ? 2 : 0;
      end else begin
        ev = 1'b1; ep = r;
        pk_port[k] = r;
        pk_mode[k] = (f == FLIT_HEADER) ? 1 : 0;
      end
    end else if (f == FLIT_BODY || f == FLIT_TAIL) begin
      if (pk_mode[k] == 0) begin
        ee = 1'b1;
      end else if (pk_mode[k] == 1) begin
        ev = 1'b1; ep = pk_port[k];
      end
      if (f == FLIT_TAIL) pk_mode[k] = 0;
    end else begin
      ee = 1'b1;
    end
  endtask

  // ---------------- stimulus helpers ----------------
  task automatic do_reset(input logic [7:0] rxy, input logic [3:0] cx, input logic [1:0] dr,
                          input logic [3:0] cur);
    @(negedge clk);
    cfg_rxy = rxy; cfg_cx = cx; cfg_dr = dr; cfg_cur = cur;
    rst = 1'b1; in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    m_rxy = rxy; m_cx = cx; m_dr = dr; m_cur = cur;
    for (int k = 0; k < 3; k++) begin
      pk_mode[k] = 0; pk_port[k] = 5'd0;
    end
  endtask

  // Offers one flit; returns #1 after the edge where it is accepted.
  task automatic send(input logic [2:0] f, input logic [3:0] d);
    @(negedge clk);
    in_valid = 1'b1; flit_id = f; dst_addr = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    @(negedge clk);
    cfg_rxy = 8'h3C; cfg_cx = 4'hF; cfg_dr = 2'd0; cfg_cur = 4'h5;
    rst = 1'b1; in_valid = 1'b1; flit_id = FLIT_HEADER; dst_addr = 4'h7;
    @(posedge clk); #1;
    tests_run++; if (ir[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_in_ready: got %b want 0", ir[0]); end
    tests_run++; if (ov[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_out_valid: got %b want 0", ov[0]); end
    tests_run++; if (op[0] !== 5'b00000) begin tests_failed++; $display("FAIL reset_out_port: got %b want 00000", op[0]); end
    tests_run++; if (re[0] !== 1'b0) begin tests_failed++; $display("FAIL reset_route_err: got %b want 0", re[0]); end
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
  endtask

  task automatic test_basic_routes();
    port_free = 4'hF; out_ready = 1'b1;
    do_reset(8'h3C, 4'hF, 2'd0, 4'h5);
    send(FLIT_HEADER, 4'h7);
    tests_run++; if (ov[0] !== 1'b1 || op[0] !== 5'b00010) begin tests_failed++; $display("FAIL east_route: got v=%b p=%b want v=1 p=00010", ov[0], op[0]); end
    send(FLIT_TAIL, 4'h0);
    tests_run++; if (op[0] !== 5'b00010 || re[0] !== 1'b0) begin tests_failed++; $display("FAIL east_tail: got p=%b e=%b want p=00010 e=0", op[0], re[0]); end
    send(FLIT_HEADER, 4'h5);
    tests_run++; if (ov[0] !== 1'b1 || op[0] !== 5'b10000) begin tests_failed++; $display("FAIL local_route: got v=%b p=%b want v=1 p=10000", ov[0], op[0]); end
    send(FLIT_TAIL, 4'h0);
    send(FLIT_HEADER, 4'h0);
    tests_run++; if (ov[0] !== 1'b1 || op[0] !== 5'b00100) begin tests_failed++; $display("FAIL west_turn: got v=%b p=%b want v=1 p=00100", ov[0], op[0]); end
    send(FLIT_TAIL, 4'h0);
  endtask

  task automatic test_adaptive();
    do_reset(8'h05, 4'hF, 2'd0, 4'h5);
    port_free = 4'b0010;
    send(FLIT_HEADER, 4'h3);
    tests_run++; if (op[0] !== 5'b00010) begin tests_failed++; $display("FAIL adapt_free_east: got %b want 00010", op[0]); end
    tests_run++; if (op[1] !== 5'b00001) begin tests_failed++; $display("FAIL fixed_prio_north: got %b want 00001", op[1]); end
    send(FLIT_TAIL, 4'h0);
    port_free = 4'hF;
    send(FLIT_HEADER, 4'h3);
    tests_run++; if (op[0] !== 5'b00001) begin tests_failed++; $display("FAIL adapt_all_free_north: got %b want 00001", op[0]); end
    send(FLIT_TAIL, 4'h0);
  endtask

  task automatic test_deroute();
    port_free = 4'hF;
    do_reset(8'h3C, 4'b1101, 2'd0, 4'h5);
    send(FLIT_HEADER, 4'h7);
    tests_run++; if (ov[0] !== 1'b1 || op[0] !== 5'b00001) begin tests_failed++; $display("FAIL deroute_north: got v=%b p=%b want v=1 p=00001", ov[0], op[0]); end
    tests_run++; if (ov[2] !== 1'b0 || re[2] !== 1'b1) begin tests_failed++; $display("FAIL drop_header: got v=%b e=%b want v=0 e=1", ov[2], re[2]); end
    send(FLIT_BODY, 4'h7);
    tests_run++; if (ov[2] !== 1'b0 || re[2] !== 1'b0) begin tests_failed++; $display("FAIL drop_body_silent: got v=%b e=%b want v=0 e=0", ov[2], re[2]); end
    send(FLIT_TAIL, 4'h7);
    tests_run++; if (ov[2] !== 1'b0 || re[2] !== 1'b0 || op[0] !== 5'b00001) begin tests_failed++; $display("FAIL drop_tail_silent: got v=%b e=%b pA=%b want v=0 e=0 pA=00001", ov[2], re[2], op[0]); end
  endtask

  task automatic test_packet();
    do_reset(8'h3C, 4'hF, 2'd0, 4'h5);
    send(FLIT_HEADER, 4'h7);
    tests_run++; if (op[0] !== 5'b00010) begin tests_failed++; $display("FAIL pkt_header: got %b want 00010", op[0]); end
    send(FLIT_BODY, 4'h0);
    tests_run++; if (ov[0] !== 1'b1 || op[0] !== 5'b00010) begin tests_failed++; $display("FAIL pkt_body_locked: got v=%b p=%b want v=1 p=00010", ov[0], op[0]); end
    send(FLIT_TAIL, 4'h0);
    tests_run++; if (ov[0] !== 1'b1 || op[0] !== 5'b00010) begin tests_failed++; $display("FAIL pkt_tail_locked: got v=%b p=%b want v=1 p=00010", ov[0], op[0]); end
    send(FLIT_HT, 4'h5);
    tests_run++; if (ov[0] !== 1'b1 || op[0] !== 5'b10000) begin tests_failed++; $display("FAIL pkt_ht_local: got v=%b p=%b want v=1 p=10000", ov[0], op[0]); end
    send(FLIT_BODY, 4'h7);
    tests_run++; if (ov[0] !== 1'b0 || re[0] !== 1'b1) begin tests_failed++; $display("FAIL stray_body: got v=%b e=%b want v=0 e=1", ov[0], re[0]); end
    @(posedge clk); #1;
    tests_run++; if (re[0] !== 1'b0) begin tests_failed++; $display("FAIL err_pulse_width: got %b want 0", re[0]); end
  endtask

  task automatic test_backpressure();
    do_reset(8'h3C, 4'hF, 2'd0, 4'h5);
    out_ready = 1'b0;
    send(FLIT_HEADER, 4'h7);
    tests_run++; if (ov[0] !== 1'b1 || op[0] !== 5'b00010) begin tests_failed++; $display("FAIL bp_first: got v=%b p=%b want v=1 p=00010", ov[0], op[0]); end
    @(negedge clk);
    in_valid = 1'b1; flit_id = FLIT_BODY; dst_addr = 4'h0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      tests_run++;
      if (ir[0] !== 1'b0 || ov[0] !== 1'b1 || op[0] !== 5'b00010) begin
        tests_failed++;
        $display("FAIL bp_stall%0d: got rdy=%b v=%b p=%b want rdy=0 v=1 p=00010", c, ir[0], ov[0], op[0]);
      end
    end
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    tests_run++; if (ov[0] !== 1'b1 || op[0] !== 5'b00010) begin tests_failed++; $display("FAIL bp_release: got v=%b p=%b want v=1 p=00010", ov[0], op[0]); end
    @(posedge clk); #1;
    tests_run++; if (ov[0] !== 1'b0) begin tests_failed++; $display("FAIL bp_drain: got v=%b want 0", ov[0]); end
  endtask

  task automatic test_reset_midpacket();
    do_reset(8'h3C, 4'hF, 2'd0, 4'h5);
    send(FLIT_HEADER, 4'h7);
    send(FLIT_BODY, 4'h0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    tests_run++; if (ov[0] !== 1'b0 || ir[0] !== 1'b0) begin tests_failed++; $display("FAIL mid_rst: got v=%b rdy=%b want v=0 rdy=0", ov[0], ir[0]); end
    @(negedge clk);
    rst = 1'b0;
    send(FLIT_BODY, 4'h7);
    tests_run++; if (ov[0] !== 1'b0 || re[0] !== 1'b1) begin tests_failed++; $display("FAIL post_rst_body: got v=%b e=%b want v=0 e=1", ov[0], re[0]); end
  endtask

  task automatic test_random();
    logic       ev;
    logic [4:0] ep;
    logic       ee;
    logic [2:0] f;
    logic [3:0] d;
    int r;
    out_ready = 1'b1;
    for (int b = 0; b < 8; b++) begin
      do_reset(8'($urandom), 4'($urandom), 2'($urandom), 4'($urandom));
      for (int i = 0; i < 40; i++) begin
        r = int'($urandom_range(9, 0));
        case (r)
          0, 1:    f = FLIT_HEADER;
          2, 3, 4: f = FLIT_BODY;
          5, 6:    f = FLIT_TAIL;
          7:       f = FLIT_HT;
          8:       f = 3'b000;
          default: f = 3'b111;
        endcase
        d = 4'($urandom);
        port_free = 4'($urandom);
        send(f, d);
        for (int k = 0; k < 3; k++) begin
          model_flit(k, f, d, ev, ep, ee);
          tests_run++;
          if (ov[k] !== ev || re[k] !== ee || (ev && op[k] !== ep)) begin
            tests_failed++;
            $display("FAIL rand_b%0d_i%0d_dut%0d: flit=%b dst=%h got v=%b p=%b e=%b want v=%b p=%b e=%b",
                     b, i, k, f, d, ov[k], op[k], re[k], ev, ep, ee);
          end
        end
      end
    end
  endtask

  initial begin
    m_adapt[0] = 1'b1; m_der[0] = 1'b1;
    m_adapt[1] = 1'b0; m_der[1] = 1'b1;
    m_adapt[2] = 1'b1; m_der[2] = 1'b0;
    rst = 1'b1; in_valid = 1'b0; flit_id = FLIT_BODY; dst_addr = 4'h0;
    port_free = 4'hF; out_ready = 1'b1;
    cfg_rxy = 8'h3C; cfg_cx = 4'hF; cfg_dr = 2'd0; cfg_cur = 4'h5;
    test_reset();
    test_basic_routes();
    test_adaptive();
    test_deroute();
    test_packet();
    test_backpressure();
    test_reset_midpacket();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
